multi_juice_vender: RTL and testbench
=====================================

MULTI_JUICE_VENDER -- requirements
Module: multi_juice_vender

Interface
REQ-001 SHALL have parameter N_KIND, default 4, number of juice kinds (2..16).
REQ-002 SHALL have parameter MONEY_W, default 16, width of money/price values.
REQ-003 SHALL have parameter NUM_W, default 3, width of order quantity.
REQ-004 SHALL have parameter PRICE_INIT, default 1000, reset price of every kind.
REQ-005 SHALL have parameter AUTO_CHANGE, default 1, 1 = return change automatically after an order.
REQ-006 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-007 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports IN_MONEY_VALID  in  1  coin strobe; IN_MONEY  in  2  coin code 00=1000, 01=500, 10=100, 11=50.
REQ-009 SHALL have ports IN_KIND  in  KW=$clog2(N_KIND)  kind select; IN_NUM  in  NUM_W  quantity; IN_BUY  in  1  order strobe.
REQ-010 SHALL have ports IN_PRICE_WE  in  1; IN_PRICE_DATA  in  MONEY_W; admin writes price[IN_KIND].
REQ-011 SHALL have port IN_RETURN  in  1  manual change request.
REQ-012 SHALL have outputs OUT_MONEY  MONEY_W  credit; OUT_PRICE  MONEY_W  price[IN_KIND], combinational.
REQ-013 SHALL have outputs OUT_JUICE_MADE  N_KIND  one-hot unit pulse; OUT_1000WON, OUT_500WON, OUT_100WON, OUT_50WON  1 each  coin-out pulses.
REQ-014 SHALL have outputs OUT_BUSY  1; OUT_ERR  1  pulse; OUT_COIN_REJ  1  pulse; END  1  pulse on return to IDLE after CHANGE.

Function
REQ-015 SHALL implement FSM states IDLE, DISPENSE, CHANGE; OUT_BUSY = (state != IDLE).
REQ-016 In IDLE, accepted coin SHALL add its value to credit next cycle; if sum > 2^MONEY_W-1, credit unchanged and OUT_COIN_REJ pulses one cycle.
REQ-017 Coins in DISPENSE or CHANGE SHALL be rejected (OUT_COIN_REJ pulse, credit unchanged).
REQ-018 IN_PRICE_WE SHALL update price[IN_KIND] only in IDLE and only when IN_BUY is low; otherwise ignored.
REQ-019 IN_BUY in IDLE SHALL latch kind and qty; cost = price*qty computed in MONEY_W+NUM_W bits without truncation.
REQ-020 If qty==0 or cost > credit, OUT_ERR SHALL pulse next cycle and state stays IDLE, credit unchanged.
REQ-021 Otherwise SHALL enter DISPENSE; each DISPENSE cycle pulses OUT_JUICE_MADE[kind], subtracts price, decrements qty; exactly qty pulses, first one cycle after IN_BUY.
REQ-022 After last unit: AUTO_CHANGE=1 -> CHANGE; AUTO_CHANGE=0 -> IDLE.
REQ-023 IN_RETURN in IDLE with IN_BUY low and credit >= 50 SHALL enter CHANGE; with credit < 50 ignored. IN_BUY wins over IN_RETURN in same cycle.
REQ-024 In CHANGE, each cycle SHALL pulse exactly one largest coin <= credit and subtract it (greedy 1000/500/100/50).
REQ-025 CHANGE SHALL exit to IDLE with END pulse in the cycle credit first falls below 50; residue < 50 stays in credit.
REQ-026 IN_BUY, IN_RETURN and IN_PRICE_WE SHALL be ignored while OUT_BUSY is high.
REQ-027 All pulses SHALL be registered, one cycle wide; at most one coin output high per cycle.

Reset
REQ-028 RST SHALL force state IDLE, credit 0, every price PRICE_INIT, latched kind/qty 0, all pulse outputs 0, immediately and regardless of CLK.
REQ-029 RST asserted mid-DISPENSE or mid-CHANGE SHALL abort with no further juice/coin pulse and credit 0.

Structure
REQ-030 Coin codes, coin values (1000/500/100/50) and FSM state encoding SHALL live in shared package vend_pkg.
REQ-031 Price storage SHALL be sub-module price_bank (N_KIND x MONEY_W registers, one write port, one read port).
REQ-032 Change selection SHALL be combinational from credit; no divider.

Verification
REQ-033 Reset, insert 1000,500,100 -> OUT_MONEY=1600, OUT_PRICE=1000 for any kind.
REQ-034 Credit 1600, buy kind 2 qty 1 price 1000, AUTO_CHANGE=1 -> one OUT_JUICE_MADE=0100 pulse, then 500 then 100 coin pulses, END, credit 0.
REQ-035 Price[1]=300, credit 1000, buy kind 1 qty 3 -> three consecutive pulses, credit 100 after DISPENSE, then one 100 pulse, END.
REQ-036 Credit 500, buy qty 2 at price 300 -> OUT_ERR pulse, no juice, credit 500; buy qty 0 -> OUT_ERR.
REQ-037 MONEY_W=12, credit 4000, insert 1000 -> OUT_COIN_REJ, credit 4000; coin during CHANGE -> OUT_COIN_REJ.
REQ-038 RST asserted during second of three DISPENSE cycles -> no further pulses, credit 0, prices = PRICE_INIT.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin codes, coin values and FSM state encoding for the juice vender.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } vend_state_e;

  localparam logic [1:0] COIN_CODE_1000 = 2'b00;
  localparam logic [1:0] COIN_CODE_500  = 2'b01;
  localparam logic [1:0] COIN_CODE_100  = 2'b10;
  localparam logic [1:0] COIN_CODE_50   = 2'b11;

  localparam int unsigned COIN_1000_VAL = 1000;
  localparam int unsigned COIN_500_VAL  = 500;
  localparam int unsigned COIN_100_VAL  = 100;
  localparam int unsigned COIN_50_VAL   = 50;

  // Face value of an inserted coin code
  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_CODE_1000: return COIN_1000_VAL;
      COIN_CODE_500:  return COIN_500_VAL;
      COIN_CODE_100:  return COIN_100_VAL;
      default:        return COIN_50_VAL;
    endcase
  endfunction

endpackage

// File: rtl/price_bank.sv
// Per-kind price registers: one write port, one combinational read port.
module price_bank #(
  parameter int unsigned N_KIND     = 4,
  parameter int unsigned MONEY_W    = 16,
  parameter int unsigned PRICE_INIT = 1000,
  localparam int unsigned KW        = $clog2(N_KIND)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [KW-1:0]      i_waddr,
  input  logic [MONEY_W-1:0] i_wdata,
  input  logic [KW-1:0]      i_raddr,
  output logic [MONEY_W-1:0] o_rdata
);

  logic [MONEY_W-1:0] r_price [N_KIND];

  // Price storage; every entry returns to the initial price on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(N_KIND); i++) r_price[i] <= MONEY_W'(PRICE_INIT);
    end else if (i_we && (32'(i_waddr) < N_KIND)) begin
      r_price[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range kinds (non power-of-two N_KIND) read as zero
  assign o_rdata = (32'(i_raddr) < N_KIND) ? r_price[i_raddr] : '0;

endmodule

// File: rtl/multi_juice_vender.sv
// Multi-kind juice vender: coin credit, priced multi-unit orders, greedy change.
module multi_juice_vender
  import vend_pkg::*;
#(
  parameter int unsigned N_KIND      = 4,
  parameter int unsigned MONEY_W     = 16,
  parameter int unsigned NUM_W       = 3,
  parameter int unsigned PRICE_INIT  = 1000,
  parameter int unsigned AUTO_CHANGE = 1,
  localparam int unsigned KW         = $clog2(N_KIND)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_MONEY_VALID,
  input  logic [1:0]         IN_MONEY,
  input  logic [KW-1:0]      IN_KIND,
  input  logic [NUM_W-1:0]   IN_NUM,
  input  logic               IN_BUY,
  input  logic               IN_PRICE_WE,
  input  logic [MONEY_W-1:0] IN_PRICE_DATA,
  input  logic               IN_RETURN,
  output logic [MONEY_W-1:0] OUT_MONEY,
  output logic [MONEY_W-1:0] OUT_PRICE,
  output logic [N_KIND-1:0]  OUT_JUICE_MADE,
  output logic               OUT_1000WON,
  output logic               OUT_500WON,
  output logic               OUT_100WON,
  output logic               OUT_50WON,
  output logic               OUT_BUSY,
  output logic               OUT_ERR,
  output logic               OUT_COIN_REJ,
  output logic               END
);

  localparam int unsigned CW = MONEY_W + NUM_W;
  localparam logic [MONEY_W-1:0] C_1000 = MONEY_W'(COIN_1000_VAL);
  localparam logic [MONEY_W-1:0] C_500  = MONEY_W'(COIN_500_VAL);
  localparam logic [MONEY_W-1:0] C_100  = MONEY_W'(COIN_100_VAL);
  localparam logic [MONEY_W-1:0] C_50   = MONEY_W'(COIN_50_VAL);

  vend_state_e        r_state;
  logic [MONEY_W-1:0] r_credit;
  logic [KW-1:0]      r_kind;
  logic [NUM_W-1:0]   r_qty;
  logic [MONEY_W-1:0] r_price;
  logic [N_KIND-1:0]  r_juice;
  logic [3:0]         r_coin;
  logic               r_err;
  logic               r_rej;
  logic               r_end;

  logic [MONEY_W-1:0] w_price;
  logic               w_price_we;
  logic [MONEY_W:0]   w_coin_val;
  logic [MONEY_W:0]   w_sum;
  logic [MONEY_W-1:0] w_idle_credit;
  logic [CW-1:0]      w_cost;
  logic               w_buy_ok;
  logic [3:0]         w_chg_coin;
  logic [MONEY_W-1:0] w_chg_val;
  logic [MONEY_W-1:0] w_chg_rem;

  // Admin price writes only land while idle and not ordering
  assign w_price_we = IN_PRICE_WE && (r_state == ST_IDLE) && !IN_BUY;

  price_bank #(
    .N_KIND     (N_KIND),
    .MONEY_W    (MONEY_W),
    .PRICE_INIT (PRICE_INIT)
  ) u_price_bank (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_price_we),
    .i_waddr (IN_KIND),
    .i_wdata (IN_PRICE_DATA),
    .i_raddr (IN_KIND),
    .o_rdata (w_price)
  );

  // Coin acceptance uses one extra bit so credit overflow is visible
  assign w_coin_val    = (MONEY_W+1)'(coin_value(IN_MONEY));
  assign w_sum         = {1'b0, r_credit} + w_coin_val;
  assign w_idle_credit = (IN_MONEY_VALID && !w_sum[MONEY_W]) ? w_sum[MONEY_W-1:0] : r_credit;

  // Order cost is kept at full width so large quantities never wrap
  assign w_cost   = CW'(w_price) * CW'(IN_NUM);
  assign w_buy_ok = (IN_NUM != '0) && (w_cost <= CW'(r_credit));

  // Greedy change: largest coin not exceeding the remaining credit
  always_comb begin
    w_chg_coin = 4'b0000;
    w_chg_val  = '0;
    if (r_credit >= C_1000) begin
      w_chg_coin = 4'b1000;
      w_chg_val  = C_1000;
    end else if (r_credit >= C_500) begin
      w_chg_coin = 4'b0100;
      w_chg_val  = C_500;
    end else if (r_credit >= C_100) begin
      w_chg_coin = 4'b0010;
      w_chg_val  = C_100;
    end else if (r_credit >= C_50) begin
      w_chg_coin = 4'b0001;
      w_chg_val  = C_50;
    end
  end

  assign w_chg_rem = r_credit - w_chg_val;

  // Vending FSM with registered pulse outputs; juice pulse leads each dispense cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_kind   <= '0;
      r_qty    <= '0;
      r_price  <= '0;
      r_juice  <= '0;
      r_coin   <= '0;
      r_err    <= 1'b0;
      r_rej    <= 1'b0;
      r_end    <= 1'b0;
    end else begin
      r_juice <= '0;
      r_coin  <= '0;
      r_err   <= 1'b0;
      r_rej   <= 1'b0;
      r_end   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rej    <= IN_MONEY_VALID && w_sum[MONEY_W];
          r_credit <= w_idle_credit;
          if (IN_BUY) begin
            if (w_buy_ok) begin
              r_state  <= ST_DISPENSE;
              r_kind   <= IN_KIND;
              r_qty    <= IN_NUM - NUM_W'(1);
              r_price  <= w_price;
              r_juice  <= N_KIND'(1) << IN_KIND;
              r_credit <= w_idle_credit - w_price;
            end else begin
              r_err <= 1'b1;
            end
          end else if (IN_RETURN && (r_credit >= C_50)) begin
            r_state <= ST_CHANGE;
          end
        end
        ST_DISPENSE: begin
          r_rej <= IN_MONEY_VALID;
          if (r_qty == '0) begin
            r_state <= (AUTO_CHANGE != 0) ? ST_CHANGE : ST_IDLE;
          end else begin
            r_juice  <= N_KIND'(1) << r_kind;
            r_credit <= r_credit - r_price;
            r_qty    <= r_qty - NUM_W'(1);
          end
        end
        ST_CHANGE: begin
          r_rej    <= IN_MONEY_VALID;
          r_coin   <= w_chg_coin;
          r_credit <= w_chg_rem;
          if (w_chg_rem < C_50) begin
            r_state <= ST_IDLE;
            r_end   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign OUT_MONEY      = r_credit;
  assign OUT_PRICE      = w_price;
  assign OUT_JUICE_MADE = r_juice;
  assign OUT_1000WON    = r_coin[3];
  assign OUT_500WON     = r_coin[2];
  assign OUT_100WON     = r_coin[1];
  assign OUT_50WON      = r_coin[0];
  assign OUT_BUSY       = (r_state != ST_IDLE);
  assign OUT_ERR        = r_err;
  assign OUT_COIN_REJ   = r_rej;
  assign END            = r_end;

endmodule

// File: tb/tb_multi_juice_vender.sv
// Directed bench for multi_juice_vender with a transaction-level reference model.
module tb_multi_juice_vender;

  localparam int N_KIND      = 4;
  localparam int MONEY_W     = 12;
  localparam int NUM_W       = 3;
  localparam int PRICE_INIT  = 1000;
  localparam int AUTO_CHANGE = 1;
  localparam int KW          = $clog2(N_KIND);
  localparam int MAXM        = (1 << MONEY_W) - 1;

  logic               CLK = 1'b0;
  logic               RST;
  logic               IN_MONEY_VALID;
  logic [1:0]         IN_MONEY;
  logic [KW-1:0]      IN_KIND;
  logic [NUM_W-1:0]   IN_NUM;
  logic               IN_BUY;
  logic               IN_PRICE_WE;
  logic [MONEY_W-1:0] IN_PRICE_DATA;
  logic               IN_RETURN;
  logic [MONEY_W-1:0] OUT_MONEY;
  logic [MONEY_W-1:0] OUT_PRICE;
  logic [N_KIND-1:0]  OUT_JUICE_MADE;
  logic               OUT_1000WON, OUT_500WON, OUT_100WON, OUT_50WON;
  logic               OUT_BUSY, OUT_ERR, OUT_COIN_REJ, end_o;

  always #5 CLK = ~CLK;

  multi_juice_vender #(
    .N_KIND(N_KIND), .MONEY_W(MONEY_W), .NUM_W(NUM_W),
    .PRICE_INIT(PRICE_INIT), .AUTO_CHANGE(AUTO_CHANGE)
  ) u_dut (
    .CLK(CLK), .RST(RST),
    .IN_MONEY_VALID(IN_MONEY_VALID), .IN_MONEY(IN_MONEY),
    .IN_KIND(IN_KIND), .IN_NUM(IN_NUM), .IN_BUY(IN_BUY),
    .IN_PRICE_WE(IN_PRICE_WE), .IN_PRICE_DATA(IN_PRICE_DATA),
    .IN_RETURN(IN_RETURN),
    .OUT_MONEY(OUT_MONEY), .OUT_PRICE(OUT_PRICE), .OUT_JUICE_MADE(OUT_JUICE_MADE),
    .OUT_1000WON(OUT_1000WON), .OUT_500WON(OUT_500WON),
    .OUT_100WON(OUT_100WON), .OUT_50WON(OUT_50WON),
    .OUT_BUSY(OUT_BUSY), .OUT_ERR(OUT_ERR), .OUT_COIN_REJ(OUT_COIN_REJ),
    .END(end_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [N_KIND-1:0] juice;
    logic [3:0]        coins;   // {1000,500,100,50}
    bit                fin;
    bit                busy;
    int                credit;
  } ent_t;

  ent_t              plan[$];
  int                m_credit;
  int                m_price [N_KIND];
  logic [N_KIND-1:0] e_juice;
  logic [3:0]        e_coins;
  bit                e_err, e_rej, e_end, e_busy;
  int                c0, c1, cost, q, p, r;
  logic [N_KIND-1:0] oh;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int cnt_juice [N_KIND];
  int cnt_c1000, cnt_c500, cnt_c100, cnt_c50, cnt_end, cnt_err, cnt_rej;

  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'b00:   return 1000;
      2'b01:   return 500;
      2'b10:   return 100;
      default: return 50;
    endcase
  endfunction

  function automatic void push(input logic [N_KIND-1:0] j, input logic [3:0] c,
                               input bit fin, input bit busy, input int cr);
    ent_t e;
    e.juice = j; e.coins = c; e.fin = fin; e.busy = busy; e.credit = cr;
    plan.push_back(e);
  endfunction

  // Change plan: one coin per cycle, largest face value that still fits
  function automatic void push_change(input int amt);
    int vals [4] = '{1000, 500, 100, 50};
    int rem;
    rem = amt;
    if (rem < 50) push('0, 4'b0000, 1'b1, 1'b0, rem);
    while (rem >= 50) begin
      for (int i = 0; i < 4; i++) begin
        if (vals[i] <= rem) begin
          rem = rem - vals[i];
          push('0, 4'(1 << (3 - i)), rem < 50, rem >= 50, rem);
          break;
        end
      end
    end
  endfunction

  function automatic void take_next();
    ent_t e;
    if (plan.size() == 0) begin
      e_busy = 1'b0;
      return;
    end
    e = plan.pop_front();
    e_juice = e.juice; e_coins = e.coins; e_end = e.fin; e_busy = e.busy; m_credit = e.credit;
  endfunction

  // Model advances on each clock edge from the inputs the DUT also sees
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_credit = 0;
      foreach (m_price[k]) m_price[k] = PRICE_INIT;
      plan.delete();
      e_juice = '0; e_coins = '0; e_err = 0; e_rej = 0; e_end = 0; e_busy = 0;
    end else begin
      e_err = 0; e_rej = 0; e_end = 0; e_juice = '0; e_coins = '0;
      if (e_busy) begin
        if (IN_MONEY_VALID) e_rej = 1;
        take_next();
      end else begin
        c0 = m_credit;
        c1 = c0;
        if (IN_MONEY_VALID) begin
          if (c0 + coin_val(IN_MONEY) > MAXM) e_rej = 1;
          else c1 = c0 + coin_val(IN_MONEY);
        end
        if (IN_BUY) begin
          p = m_price[IN_KIND];
          q = int'(IN_NUM);
          cost = p * q;
          if (q == 0 || cost > c0) begin
            e_err = 1;
            m_credit = c1;
          end else begin
            oh = '0;
            oh[IN_KIND] = 1'b1;
            for (int i = 1; i <= q; i++) push(oh, 4'b0000, 1'b0, 1'b1, c1 - i * p);
            r = c1 - q * p;
            push('0, 4'b0000, 1'b0, AUTO_CHANGE != 0, r);
            if (AUTO_CHANGE != 0) push_change(r);
            take_next();
          end
        end else begin
          if (IN_PRICE_WE) m_price[IN_KIND] = int'(IN_PRICE_DATA);
          if (IN_RETURN && c0 >= 50) begin
            push('0, 4'b0000, 1'b0, 1'b1, c1);
            push_change(c1);
            take_next();
          end else begin
            m_credit = c1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus pulse tallies
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("money", 64'(OUT_MONEY), 64'(m_credit));
      chk("price", 64'(OUT_PRICE), 64'(m_price[IN_KIND]));
      chk("juice", 64'(OUT_JUICE_MADE), 64'(e_juice));
      chk("coins", 64'({OUT_1000WON, OUT_500WON, OUT_100WON, OUT_50WON}), 64'(e_coins));
      chk("err", 64'(OUT_ERR), 64'(e_err));
      chk("rej", 64'(OUT_COIN_REJ), 64'(e_rej));
      chk("end", 64'(end_o), 64'(e_end));
      chk("busy", 64'(OUT_BUSY), 64'(e_busy));
      for (int k = 0; k < N_KIND; k++) if (OUT_JUICE_MADE[k]) cnt_juice[k]++;
      if (OUT_1000WON) cnt_c1000++;
      if (OUT_500WON)  cnt_c500++;
      if (OUT_100WON)  cnt_c100++;
      if (OUT_50WON)   cnt_c50++;
      if (end_o)       cnt_end++;
      if (OUT_ERR)     cnt_err++;
      if (OUT_COIN_REJ) cnt_rej++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic clr_cnt();
    foreach (cnt_juice[k]) cnt_juice[k] = 0;
    cnt_c1000 = 0; cnt_c500 = 0; cnt_c100 = 0; cnt_c50 = 0;
    cnt_end = 0; cnt_err = 0; cnt_rej = 0;
  endtask

  task automatic coin(input logic [1:0] code);
    IN_MONEY_VALID = 1'b1;
    IN_MONEY = code;
    tick();
    IN_MONEY_VALID = 1'b0;
  endtask

  task automatic buy(input int kind, input int num);
    IN_KIND = KW'(kind);
    IN_NUM  = NUM_W'(num);
    IN_BUY  = 1'b1;
    tick();
    IN_BUY  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (OUT_BUSY && n < 60) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(OUT_BUSY), 64'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    IN_MONEY_VALID = 0; IN_MONEY = '0; IN_KIND = '0; IN_NUM = '0; IN_BUY = 0;
    IN_PRICE_WE = 0; IN_PRICE_DATA = '0; IN_RETURN = 0;
    clr_cnt();
    tick();
    chk_en = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("rst_money", 64'(OUT_MONEY), 64'(0));
    chk("rst_busy", 64'(OUT_BUSY), 64'(0));
    chk("rst_price", 64'(OUT_PRICE), 64'(1000));

    // Credit accumulation and initial prices
    coin(2'b00); coin(2'b01); coin(2'b10);
    chk("credit_1600", 64'(OUT_MONEY), 64'(1600));
    for (int k = 0; k < N_KIND; k++) begin
      IN_KIND = KW'(k);
      #1;
      chk("init_price", 64'(OUT_PRICE), 64'(1000));
    end

    // Single unit with 600 change
    clr_cnt();
    buy(2, 1);
    wait_idle();
    chk("s1_juice2", 64'(cnt_juice[2]), 64'(1));
    chk("s1_c500", 64'(cnt_c500), 64'(1));
    chk("s1_c100", 64'(cnt_c100), 64'(1));
    chk("s1_c1000", 64'(cnt_c1000), 64'(0));
    chk("s1_end", 64'(cnt_end), 64'(1));
    chk("s1_money", 64'(OUT_MONEY), 64'(0));

    // Three units at price 300
    IN_KIND = 1; IN_PRICE_WE = 1; IN_PRICE_DATA = 300;
    tick();
    IN_PRICE_WE = 0;
    chk("price1_300", 64'(OUT_PRICE), 64'(300));
    coin(2'b00);
    clr_cnt();
    buy(1, 3);
    tick(); tick();
    chk("s2_mid_money", 64'(OUT_MONEY), 64'(100));
    wait_idle();
    chk("s2_juice1", 64'(cnt_juice[1]), 64'(3));
    chk("s2_c100", 64'(cnt_c100), 64'(1));
    chk("s2_end", 64'(cnt_end), 64'(1));
    chk("s2_money", 64'(OUT_MONEY), 64'(0));

    // Insufficient credit and zero quantity
    coin(2'b01);
    clr_cnt();
    buy(1, 2);
    tick();
    chk("s3_err1", 64'(cnt_err), 64'(1));
    chk("s3_nojuice", 64'(cnt_juice[1]), 64'(0));
    chk("s3_money", 64'(OUT_MONEY), 64'(500));
    buy(1, 0);
    tick();
    chk("s3_err2", 64'(cnt_err), 64'(2));
    chk("s3_busy", 64'(OUT_BUSY), 64'(0));

    // Manual return of 1650 with a coin inserted during change
    coin(2'b00); coin(2'b10); coin(2'b11);
    clr_cnt();
    IN_RETURN = 1;
    tick();
    IN_RETURN = 0;
    tick();
    coin(2'b00);
    wait_idle();
    chk("s4_c1000", 64'(cnt_c1000), 64'(1));
    chk("s4_c500", 64'(cnt_c500), 64'(1));
    chk("s4_c100", 64'(cnt_c100), 64'(1));
    chk("s4_c50", 64'(cnt_c50), 64'(1));
    chk("s4_rej", 64'(cnt_rej), 64'(1));
    chk("s4_money", 64'(OUT_MONEY), 64'(0));
    IN_RETURN = 1;
    tick();
    IN_RETURN = 0;
    chk("s4_ret_ignored", 64'(OUT_BUSY), 64'(0));

    // Credit overflow at MONEY_W=12
    repeat (4) coin(2'b00);
    clr_cnt();
    coin(2'b00);
    tick();
    chk("s5_rej", 64'(cnt_rej), 64'(1));
    chk("s5_money", 64'(OUT_MONEY), 64'(4000));
    coin(2'b11);
    coin(2'b11);
    tick();
    chk("s5_rej2", 64'(cnt_rej), 64'(2));
    chk("s5_money2", 64'(OUT_MONEY), 64'(4050));
    clr_cnt();
    IN_RETURN = 1;
    tick();
    IN_RETURN = 0;
    wait_idle();
    chk("s5_c1000", 64'(cnt_c1000), 64'(4));
    chk("s5_c50", 64'(cnt_c50), 64'(1));
    chk("s5_money3", 64'(OUT_MONEY), 64'(0));

    // Buy beats return; price writes with buy or while busy are dropped
    coin(2'b00);
    clr_cnt();
    IN_KIND = 0; IN_NUM = 1; IN_BUY = 1; IN_RETURN = 1;
    IN_PRICE_WE = 1; IN_PRICE_DATA = 7;
    tick();
    IN_BUY = 0; IN_RETURN = 0;
    IN_KIND = 2; IN_PRICE_DATA = 5;
    tick();
    IN_PRICE_WE = 0;
    wait_idle();
    chk("s6_juice0", 64'(cnt_juice[0]), 64'(1));
    chk("s6_end", 64'(cnt_end), 64'(1));
    chk("s6_nocoin", 64'(cnt_c1000 + cnt_c500 + cnt_c100 + cnt_c50), 64'(0));
    chk("s6_price2", 64'(OUT_PRICE), 64'(1000));
    IN_KIND = 0;
    #1;
    chk("s6_price0", 64'(OUT_PRICE), 64'(1000));

    // Reset during second of three dispense cycles
    coin(2'b00);
    clr_cnt();
    buy(1, 3);
    tick();
    @(negedge CLK);
    #1;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick(); tick();
    IN_KIND = 1;
    #1;
    chk("s7_juice1", 64'(cnt_juice[1]), 64'(2));
    chk("s7_money", 64'(OUT_MONEY), 64'(0));
    chk("s7_price1", 64'(OUT_PRICE), 64'(PRICE_INIT));
    chk("s7_busy", 64'(OUT_BUSY), 64'(0));

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
